// File: rtl/player_pkg.sv
// Shared types and track-length decoding for the beat sequencer and its helpers.
// The top-level width parameters default to the values held here and must stay in step with them.
package player_pkg;

   localparam int DEF_IBEAT_W    = 12;
   localparam int DEF_NUM_TRACKS = 4;
   localparam int DEF_TRK_W      = 2;
   localparam int DEF_LEN_W      = DEF_IBEAT_W + 1;
   localparam int DEF_SLOW_DIV   = 2;

   // Entry [0] sits in the least significant slice.
   localparam logic [DEF_NUM_TRACKS*DEF_LEN_W-1:0] DEF_TRACK_LEN =
      {13'd1024, 13'd2048, 13'd4095, 13'd4095};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } seq_state_e;

   function automatic logic [DEF_LEN_W-1:0] track_len(
      input logic [DEF_NUM_TRACKS*DEF_LEN_W-1:0] lens,
      input logic [DEF_TRK_W-1:0]                trk
   );
      return lens[trk*DEF_LEN_W +: DEF_LEN_W];
   endfunction

endpackage

// File: rtl/beat_prescaler.sv
// Divides qualified beat ticks by SLOW_DIV when slow playback is selected.
// With slow low, every qualified tick is a step and the count is held at zero.
module beat_prescaler #(
   parameter int SLOW_DIV = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_slow,
   input  logic i_tick,
   output logic o_step_en
);

   localparam int CNT_W = (SLOW_DIV > 2) ? $clog2(SLOW_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(SLOW_DIV - 1);

   logic [CNT_W-1:0] r_presc;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_presc <= '0;
      end else if (i_clear || !i_slow) begin
         r_presc <= '0;
      end else if (i_tick) begin
         r_presc <= (r_presc == LAST) ? '0 : r_presc + 1'b1;
      end
   end

   assign o_step_en = i_tick & (!i_slow | (r_presc == LAST));

endmodule

// File: rtl/beat_sequencer.sv
// Multi-track beat sequencer: steps ibeat through the selected track on beat ticks,
// with slow division, loop/one-shot end handling, restart and track switching.
module beat_sequencer
   import player_pkg::*;
#(
   parameter int                                     IBEAT_W    = DEF_IBEAT_W,
   parameter int                                     NUM_TRACKS = DEF_NUM_TRACKS,
   parameter int                                     TRK_W      = DEF_TRK_W,
   parameter logic [NUM_TRACKS*(IBEAT_W+1)-1:0]      TRACK_LEN  = DEF_TRACK_LEN,
   parameter int                                     SLOW_DIV   = DEF_SLOW_DIV
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_beat_tick,
   input  logic               i_play,
   input  logic               i_mode,
   input  logic               i_slow,
   input  logic               i_loop_en,
   input  logic               i_restart,
   input  logic [TRK_W-1:0]   i_track_sel,
   output logic [IBEAT_W-1:0] o_ibeat,
   output logic [TRK_W-1:0]   o_track,
   output logic               o_beat_strobe,
   output logic               o_done
);

   seq_state_e         r_state;
   seq_state_e         w_nextState;
   logic [IBEAT_W-1:0] r_ibeat;
   logic [IBEAT_W-1:0] w_nextIbeat;
   logic [TRK_W-1:0]   r_track;
   logic               r_strobe;
   logic               r_done;

   logic               w_go;
   logic               w_trkChg;
   logic               w_clear;
   logic               w_runTick;
   logic               w_stepEn;
   logic               w_step;
   logic               w_leaveRun;
   logic [IBEAT_W:0]   w_len;
   logic [IBEAT_W:0]   w_lastBeat;
   logic [IBEAT_W:0]   w_ibeatInc;
   logic               w_atEnd;

   assign w_go       = i_play & i_mode;
   assign w_trkChg   = (i_track_sel != r_track);
   assign w_clear    = i_restart | w_trkChg;
   assign w_runTick  = i_beat_tick & (r_state == RUN);
   assign w_step     = w_stepEn & ~w_clear;
   assign w_leaveRun = (r_state == RUN) && (w_nextState != RUN);

   // Lengths may reach 2**IBEAT_W, so the end test is done one bit wider than ibeat.
   assign w_len      = track_len(TRACK_LEN, r_track);
   assign w_lastBeat = w_len - 1'b1;
   assign w_ibeatInc = {1'b0, r_ibeat} + 1'b1;
   assign w_atEnd    = !(w_ibeatInc < w_len);

   beat_prescaler #(
      .SLOW_DIV (SLOW_DIV)
   ) u_prescaler (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_clear   (w_clear | w_leaveRun),
      .i_slow    (i_slow),
      .i_tick    (w_runTick),
      .o_step_en (w_stepEn)
   );

   // Restart and track change override stepping; the step of that cycle is dropped.
   always_comb begin
      w_nextState = r_state;
      w_nextIbeat = r_ibeat;
      if (w_clear) begin
         w_nextState = w_go ? RUN : IDLE;
         w_nextIbeat = '0;
      end else begin
         case (r_state)
            IDLE:    if (w_go) w_nextState = RUN;
            RUN: begin
               if (w_step && w_atEnd && !i_loop_en) w_nextState = DONE;
               else if (!w_go)                      w_nextState = PAUSE;
            end
            PAUSE:   if (w_go) w_nextState = RUN;
            DONE:    w_nextState = DONE;
            default: w_nextState = IDLE;
         endcase
         if (w_step) begin
            if (!w_atEnd)       w_nextIbeat = w_ibeatInc[IBEAT_W-1:0];
            else if (i_loop_en) w_nextIbeat = '0;
            else                w_nextIbeat = w_lastBeat[IBEAT_W-1:0];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_ibeat  <= '0;
         r_track  <= '0;
         r_strobe <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_ibeat  <= w_nextIbeat;
         r_strobe <= w_step;
         r_done   <= (w_nextState == DONE);
         if (w_trkChg) r_track <= i_track_sel;
      end
   end

   assign o_ibeat       = r_ibeat;
   assign o_track       = r_track;
   assign o_beat_strobe = r_strobe;
   assign o_done        = r_done;

endmodule

// File: tb/tb_beat_sequencer.sv
// Table-driven bench for beat_sequencer with a cycle-level scoreboard fed by a behavioural model.
// Inputs change on the falling edge; outputs are sampled on the following falling edge.
module tb_beat_sequencer;

   localparam int SLOW_DIV = 2;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

   logic        clk = 1'b0;
   logic        rstN;
   logic        beatTick, play, mode, slow, loopEn, restart;
   logic [1:0]  trackSel;
   logic [11:0] oIbeat;
   logic [1:0]  oTrack;
   logic        oStrobe, oDone;

   typedef struct packed {
      logic [11:0] ibeat;
      logic [1:0]  track;
      logic        strobe;
      logic        done;
   } exp_t;

   typedef struct {
      bit         play;
      bit         mode;
      bit         slow;
      bit         loopEn;
      bit         restart;
      logic [1:0] trk;
      int         ticks;
      int         expIbeat;
      int         expTrack;
      bit         expDone;
      int         expStrobes;
   } vecRow_t;

   exp_t    sbQ[$];
   vecRow_t vecs[13];
   int      errors = 0;
   int      checks = 0;
   int      strobeCnt;
   int      mIbeat, mTrack, mState, mPresc;

   always #5 clk = ~clk;

   beat_sequencer dut (
      .i_clk         (clk),
      .i_rst_n       (rstN),
      .i_beat_tick   (beatTick),
      .i_play        (play),
      .i_mode        (mode),
      .i_slow        (slow),
      .i_loop_en     (loopEn),
      .i_restart     (restart),
      .i_track_sel   (trackSel),
      .o_ibeat       (oIbeat),
      .o_track       (oTrack),
      .o_beat_strobe (oStrobe),
      .o_done        (oDone)
   );

   function automatic int lenOf(input int trk);
      case (trk)
         2:       return 2048;
         3:       return 1024;
         default: return 4095;
      endcase
   endfunction

   task automatic checkVal(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic modelReset();
      mIbeat = 0;
      mTrack = 0;
      mState = M_IDLE;
      mPresc = 0;
   endtask

   // Reference behaviour for one clock edge, using the inputs currently driven.
   task automatic modelStep();
      bit   go, clr, step, toDone;
      int   ns;
      exp_t e;
      go     = play && mode;
      clr    = restart || (int'(trackSel) != mTrack);
      step   = !clr && (mState == M_RUN) && beatTick && (!slow || mPresc == SLOW_DIV - 1);
      toDone = 1'b0;
      ns     = mState;
      if (clr) begin
         mTrack = int'(trackSel);
         mIbeat = 0;
         mPresc = 0;
         ns     = go ? M_RUN : M_IDLE;
      end else begin
         if (step) begin
            if (mIbeat + 1 < lenOf(mTrack)) mIbeat = mIbeat + 1;
            else if (loopEn)                mIbeat = 0;
            else                            toDone = 1'b1;
         end
         case (mState)
            M_IDLE:  if (go) ns = M_RUN;
            M_RUN:   if (toDone) ns = M_DONE; else if (!go) ns = M_PAUSE;
            M_PAUSE: if (go) ns = M_RUN;
            default: ns = mState;
         endcase
         if (!slow || (mState == M_RUN && ns != M_RUN)) mPresc = 0;
         else if (mState == M_RUN && beatTick)         mPresc = (mPresc == SLOW_DIV - 1) ? 0 : mPresc + 1;
      end
      mState   = ns;
      e.ibeat  = 12'(mIbeat);
      e.track  = 2'(mTrack);
      e.strobe = step;
      e.done   = (ns == M_DONE);
      sbQ.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t e;
      checks++;
      if (sbQ.size() == 0) begin
         errors++;
         $display("[TB] FAIL scoreboard: no expected entry for ibeat=%0d", oIbeat);
      end else begin
         e = sbQ.pop_front();
         if ({oIbeat, oTrack, oStrobe, oDone} != e) begin
            errors++;
            $display("[TB] FAIL cycle: got ibeat=%0d track=%0d strobe=%0b done=%0b expected ibeat=%0d track=%0d strobe=%0b done=%0b",
                     oIbeat, oTrack, oStrobe, oDone, e.ibeat, e.track, e.strobe, e.done);
         end
      end
      if (oStrobe) strobeCnt++;
   endtask

   task automatic driveCycle(input bit tick, input bit rst);
      beatTick = tick;
      restart  = rst;
      modelStep();
      @(posedge clk);
      @(negedge clk);
      checkOutput();
      beatTick = 1'b0;
      restart  = 1'b0;
   endtask

   // One setup cycle applies levels and any restart/track change, then ticks with idle gaps.
   task automatic applyStimulus(input vecRow_t v, input int idx);
      play      = v.play;
      mode      = v.mode;
      slow      = v.slow;
      loopEn    = v.loopEn;
      trackSel  = v.trk;
      strobeCnt = 0;
      driveCycle(1'b0, v.restart);
      for (int i = 0; i < v.ticks; i++) begin
         driveCycle(1'b1, 1'b0);
         driveCycle(1'b0, 1'b0);
      end
      checkVal($sformatf("row%0d ibeat", idx),   int'(oIbeat), v.expIbeat);
      checkVal($sformatf("row%0d track", idx),   int'(oTrack), v.expTrack);
      checkVal($sformatf("row%0d done", idx),    int'(oDone),  int'(v.expDone));
      checkVal($sformatf("row%0d strobes", idx), strobeCnt,    v.expStrobes);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      //          play mode slow loop rst trk ticks ibeat trk done strobes
      vecs[0]  = '{1, 1, 0, 1, 0, 2'd2, 2048,    0, 2, 0, 2048};
      vecs[1]  = '{1, 1, 0, 0, 0, 2'd3, 1024, 1023, 3, 1, 1024};
      vecs[2]  = '{1, 1, 0, 0, 0, 2'd3,   10, 1023, 3, 1,    0};
      vecs[3]  = '{1, 1, 0, 0, 1, 2'd3,    0,    0, 3, 0,    0};
      vecs[4]  = '{1, 1, 1, 0, 0, 2'd3,   10,    5, 3, 0,    5};
      vecs[5]  = '{0, 1, 1, 0, 0, 2'd3,    4,    5, 3, 0,    0};
      vecs[6]  = '{1, 1, 1, 0, 0, 2'd3,    3,    6, 3, 0,    1};
      vecs[7]  = '{1, 1, 0, 0, 0, 2'd3,    2,    8, 3, 0,    2};
      vecs[8]  = '{1, 0, 0, 0, 0, 2'd3,   20,    8, 3, 0,    0};
      vecs[9]  = '{1, 1, 0, 0, 0, 2'd3,    3,   11, 3, 0,    3};
      vecs[10] = '{1, 1, 0, 1, 0, 2'd0,  300,  300, 0, 0,  300};
      vecs[11] = '{1, 1, 0, 1, 0, 2'd1,   77,   77, 1, 0,   77};
      vecs[12] = '{1, 1, 0, 1, 1, 2'd2,    5,    5, 2, 0,    5};

      rstN = 1'b0; beatTick = 1'b0; play = 1'b0; mode = 1'b0; slow = 1'b0;
      loopEn = 1'b0; restart = 1'b0; trackSel = 2'd0;
      modelReset();
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      checkVal("reset ibeat",  int'(oIbeat),  0);
      checkVal("reset track",  int'(oTrack),  0);
      checkVal("reset strobe", int'(oStrobe), 0);
      checkVal("reset done",   int'(oDone),   0);

      for (int r = 0; r <= 10; r++) applyStimulus(vecs[r], r);

      // Track switch coinciding with a beat tick: new track, beat 0, tick discarded.
      trackSel = 2'd1;
      driveCycle(1'b1, 1'b0);
      checkVal("switch track",  int'(oTrack),  1);
      checkVal("switch ibeat",  int'(oIbeat),  0);
      checkVal("switch strobe", int'(oStrobe), 0);
      driveCycle(1'b0, 1'b0);

      applyStimulus(vecs[11], 11);

      // Asynchronous reset between clock edges.
      #2 rstN = 1'b0;
      #1;
      checkVal("async ibeat",  int'(oIbeat),  0);
      checkVal("async track",  int'(oTrack),  0);
      checkVal("async strobe", int'(oStrobe), 0);
      checkVal("async done",   int'(oDone),   0);
      modelReset();
      sbQ.delete();
      @(negedge clk);
      rstN = 1'b1;

      applyStimulus(vecs[12], 12);

      checkVal("scoreboard drained", sbQ.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
